uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver: converts the asynchronous `rx` line into bytes presented on a valid/ready stream.
- Receive-side counterpart to the transmit path that `top` drives out.
- Sits between the board RX pin and the core logic, in the 100 MHz `clk` domain.
- 8N1 framing by default; LSB first.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); must be >= 4.
- DATA_BITS, 8, payload bits per frame (5..8).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset: one clock; reset is synchronous and active-high.
- rx  input  1  asynchronous serial line, idle high.
- m_data  output  DATA_BITS  received byte; stable while m_valid=1.
- m_valid  output  1  byte available.
- m_ready  input  1  consumer accepts when m_valid&&m_ready at posedge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: new byte dropped because holding register full.

Behaviour:
- Reset values: m_data=0, m_valid=0, frame_err=0, overrun=0.
- Reset also sets: state=IDLE, counters=0, synchronizer flops=1.
- Synchronizer: `rx` passes through 2 flops; `rx_s` is the second flop. All decisions use `rx_s`.
- IDLE:
  - Bit counter is cleared.
  - `rx_s`=0 -> START, with baud counter=0.
- START:
  - At count CLKS_PER_BIT/2-1 (integer division), sample `rx_s`.
  - Sample 0 -> DATA, baud counter=0.
  - Sample 1 -> false start, back to IDLE with no outputs.
- DATA:
  - Sample `rx_s` each time the baud counter reaches CLKS_PER_BIT-1; counter then resets to 0.
  - Shift samples in LSB first.
  - After DATA_BITS samples -> STOP (or PARITY when the option is enabled).
- STOP: sample at count CLKS_PER_BIT-1.
  - Sample 1 -> frame good: deliver the byte, go to IDLE.
  - Sample 0 -> pulse frame_err, discard the byte, go to BREAK.
- BREAK: wait until `rx_s`=1, then IDLE. A continuous low line produces no further frames.
- Delivery, on the cycle after the good stop sample:
  - If m_valid=0, or m_ready=1 that same cycle: load m_data, m_valid=1, no overrun.
  - Otherwise: pulse overrun, drop the new byte; m_data and m_valid unchanged.
- Handshake:
  - m_valid falls on the cycle after acceptance unless a new byte loads on that same cycle.
  - m_data must not change while m_valid=1 and m_ready=0.
- Latency: m_valid rises about 2 (sync) + (DATA_BITS+1.5)*CLKS_PER_BIT cycles after the start-bit falling edge.
- Reset mid-frame: asserting `rst` returns to IDLE on the next edge and clears any held byte.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at count CLKS_PER_BIT-1.
  - Parity is even.
  - Adds output port parity_err (1 bit): one-cycle pulse on the cycle after the stop sample when parity mismatched.
  - On parity mismatch, the byte is discarded (not delivered); frame_err takes precedence if both errors occur.
- Undefined: no PARITY state, no parity_err port; frame is 8N1.

Decomposition:
- Package uart_pkg:
  - `rx_state_e` enum {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - Default CLKS_PER_BIT constant.
  - Function computing baud counter width, $clog2(CLKS_PER_BIT).
- Sub-module uart_rx_sync: 2-flop synchronizer, reset to 1, parameterised width.
- Everything else stays in uart_rx.

Test Plan:
Simulate with CLKS_PER_BIT=16 and m_ready=1 unless stated.
1. Send 0xA5 (bit sequence 0,1,0,1,0,0,1,0,1,1) -> exactly one m_valid beat with m_data=0xA5; no error pulses.
2. Low glitch of 4 cycles on `rx` while idle -> no m_valid, no frame_err; a following 0x3C frame is received correctly.
3. Frame 0x55 with stop bit forced 0, line held low 40 cycles, then 0x0F -> one frame_err pulse, 0x55 never presented, then m_data=0x0F.
4. m_ready=0: send 0x11 then 0x22 -> m_data stays 0x11 and overrun pulses once at the 0x22 stop. After raising m_ready, 0x11 is accepted and m_valid drops.
5. Hold m_valid with 0x33 and raise m_ready exactly on the delivery cycle of 0x44 -> no overrun; m_data=0x44 next cycle.
6. Assert rst for 1 cycle at mid-frame (bit 3 of 0x99) -> m_valid=0, state IDLE. The next full frame 0xC3 is received correctly.
7. With UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> parity_err pulse, no m_valid; 0x07 with parity bit 1 -> delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_e     - receiver FSM states
//   CLKS_PER_BIT_DEFAULT - 100 MHz / 115200 baud
//   baud_cnt_width - width of a counter that must hold 0..clks_per_bit-1
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    function automatic int unsigned baud_cnt_width(input int unsigned clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for asynchronous inputs; flops reset to 1
// so an idle-high serial line does not look like a start bit out of reset.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   d_i - asynchronous input
//   q_o - synchronized output (second flop)
module uart_rx_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: serial UART receiver, 8N1 by default, LSB first. Received bytes are
// presented on a valid/ready stream with a single holding register.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data and stop bits, plus the parity_err output.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   rx         - asynchronous serial line, idle high
//   m_data     - received byte, stable while m_valid is high
//   m_valid    - byte available
//   m_ready    - consumer accepts on m_valid && m_ready at posedge
//   frame_err  - one-cycle pulse: stop bit sampled low
//   overrun    - one-cycle pulse: new byte dropped, holding register full
//   parity_err - (UART_RX_PARITY_EN only) one-cycle pulse: parity mismatch
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int unsigned CntW = baud_cnt_width(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_sync #(
        .WIDTH(1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d_i(rx),
        .q_o(rx_s)
    );

    rx_state_e            state_q, state_d;
    logic [CntW-1:0]      baud_q, baud_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 deliver_q, deliver_d;
    logic [DATA_BITS-1:0] m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        deliver_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                bit_d  = '0;
                baud_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == HalfCnt) begin
                    baud_d  = '0;
                    // Line back high at mid start bit means a glitch, not a frame.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == FullCnt) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LastBit) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_q == FullCnt) begin
                    baud_d    = '0;
                    // Even parity: the parity bit equals the XOR of the data bits.
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_q == FullCnt) begin
                    baud_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end else begin
                        deliver_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            BREAK: begin
                // Held-low line: wait for it to return high before hunting again.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register: the new byte loads only if the slot is empty or is
    // being drained on this very edge; otherwise it is dropped.
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        overrun_d = 1'b0;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = shift_q;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            deliver_q   <= deliver_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
